// File: rtl/key_debounce_multi_pkg.sv
// Shared state encoding and time conversion for the key conditioner.
package key_pkg;

    typedef logic [1:0] key_state_t;

    localparam key_state_t ST_IDLE       = 2'd0;
    localparam key_state_t ST_PRESS_DB   = 2'd1;
    localparam key_state_t ST_HELD       = 2'd2;
    localparam key_state_t ST_RELEASE_DB = 2'd3;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key pins in, conditioned levels and event pulses out; master drives pins, slave is the conditioner.
interface key_debounce_multi_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] long_pulse;
    logic [NUM_KEYS-1:0] repeat_pulse;

    modport master (
        output key_in,
        input  key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
    );

    modport slave (
        input  key_in,
        output key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/key_debounce_multi_ch.sv
// One key channel: 2-flop sync, debounce FSM, long-press and auto-repeat timers; press after DB_CYC+2 edges.
// No backpressure: registered single-cycle pulses, at most one event per cycle.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DB_CYC     = 5,
    parameter int unsigned LONG_CYC   = 20,
    parameter int unsigned REP_CYC    = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);
    localparam int unsigned DB_W   = $clog2(DB_CYC + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
    localparam int unsigned REP_W  = (REP_CYC > 0) ? $clog2(REP_CYC + 1) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REP_CYC > 0) ? REP_CYC - 1 : 0);

    logic              sync1_q, sync2_q;
    key_state_t        state_q, state_d;
    logic [DB_W-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              long_done_q, long_done_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              pressed;

    assign pressed = sync2_q ^ ACTIVE_LOW;

    // Sync flops reset to the released pin level so reset exit never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= ACTIVE_LOW;
            sync2_q     <= ACTIVE_LOW;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            rep_q       <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync1_q     <= key_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        rep_d       = rep_q;
        long_done_d = long_done_q;
        case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    state_d = ST_PRESS_DB;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = ST_HELD;
                    cnt_d       = '0;
                    hold_d      = '0;
                    rep_d       = '0;
                    long_done_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                // Hold and repeat timers freeze outside HELD so a release bounce does not restart them.
                if (!pressed) begin
                    state_d = ST_RELEASE_DB;
                    cnt_d   = '0;
                end else if (!long_done_q) begin
                    if (hold_q == HOLD_LAST) begin
                        long_done_d = 1'b1;
                        rep_d       = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end else if (REP_CYC > 0) begin
                    rep_d = (rep_q == REP_LAST) ? '0 : rep_q + 1'b1;
                end
            end
            ST_RELEASE_DB: begin
                if (pressed) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_PRESS_DB: begin
                if (pressed && cnt_q == DB_LAST) begin
                    press_d = 1'b1;
                    level_d = 1'b1;
                end
            end
            ST_HELD: begin
                if (pressed && !long_done_q && hold_q == HOLD_LAST) begin
                    long_d = 1'b1;
                end else if (pressed && long_done_q && REP_CYC > 0 && rep_q == REP_LAST) begin
                    repeat_d = 1'b1;
                end
            end
            ST_RELEASE_DB: begin
                if (!pressed && cnt_q == DB_LAST) begin
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end
            end
            default: begin
                level_d = 1'b0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_multi.sv
// N independent key conditioners; press/release pulse DB_CYC+2 edges after a stable pin change.
// No backpressure: all outputs are registered pulses/levels, channels never interact.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 4,
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    key_debounce_multi_if.slave   kif
);
    localparam int unsigned DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
    localparam int unsigned REP_CYC  = ms_to_cycles(CLK_HZ, REPEAT_MS);

    if (DB_CYC < 1) begin : g_bad_db
        $error("key_debounce_multi: debounce time must be at least one clock");
    end
    if (LONG_CYC <= DB_CYC) begin : g_bad_long
        $error("key_debounce_multi: long-press time must exceed debounce time");
    end
    if (NUM_KEYS < 1) begin : g_bad_keys
        $error("key_debounce_multi: need at least one key");
    end

    logic [NUM_KEYS-1:0] level_w, press_w, release_w, long_w, repeat_w;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DB_CYC     (DB_CYC),
            .LONG_CYC   (LONG_CYC),
            .REP_CYC    (REP_CYC),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_i     (kif.key_in[i]),
            .level_o   (level_w[i]),
            .press_o   (press_w[i]),
            .release_o (release_w[i]),
            .long_o    (long_w[i]),
            .repeat_o  (repeat_w[i])
        );
    end

    assign kif.key_level     = level_w;
    assign kif.press_pulse   = press_w;
    assign kif.release_pulse = release_w;
    assign kif.long_pulse    = long_w;
    assign kif.repeat_pulse  = repeat_w;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench: DB_CYC=5, LONG_CYC=20, REP_CYC=4, active-low pins; edge 0 is the first edge after a pin change.
module tb_key_debounce_multi;
    localparam int NK = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    key_debounce_multi_if #(.NUM_KEYS(NK)) kif ();

    key_debounce_multi #(
        .NUM_KEYS    (NK),
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (5),
        .LONG_MS     (20),
        .REPEAT_MS   (4),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif.slave)
    );

    typedef struct {
        logic [NK-1:0] key;
        int            n;
        logic [NK-1:0] lvl;
        logic [NK-1:0] prs;
        logic [NK-1:0] rls;
        logic [NK-1:0] lng;
        logic [NK-1:0] rpt;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic [NK-1:0] key, input int n, input logic [NK-1:0] lvl,
                       input logic [NK-1:0] prs, input logic [NK-1:0] rls,
                       input logic [NK-1:0] lng, input logic [NK-1:0] rpt);
        vec_t v;
        v.key = key; v.n = n; v.lvl = lvl; v.prs = prs; v.rls = rls; v.lng = lng; v.rpt = rpt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive pins at a falling edge, pass n rising edges, return any pulse seen before the last one.
    task automatic run(input logic [NK-1:0] key, input int n, output logic [NK-1:0] mid);
        kif.key_in = key;
        mid = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < n - 1)
                mid |= kif.press_pulse | kif.release_pulse | kif.long_pulse | kif.repeat_pulse;
        end
    endtask

    task automatic chk_all(input string name, input logic [NK-1:0] lvl, input logic [NK-1:0] prs,
                           input logic [NK-1:0] rls, input logic [NK-1:0] lng, input logic [NK-1:0] rpt);
        chk({name, ".level"},   kif.key_level,     lvl);
        chk({name, ".press"},   kif.press_pulse,   prs);
        chk({name, ".release"}, kif.release_pulse, rls);
        chk({name, ".long"},    kif.long_pulse,    lng);
        chk({name, ".repeat"},  kif.repeat_pulse,  rpt);
    endtask

    initial begin
        logic [NK-1:0] mid;

        // Keys 0 and 3 together, short hold: press at 7, release 7 edges after the pin lets go.
        add(4'b0110, 7,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0110, 1,  4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0110, 2,  4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1111, 7,  4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1111, 1,  4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
        add(4'b1111, 3,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Key 2 held 40 edges: press 7, long 27, repeat 31/35/39, release at 47, no repeat at 43.
        add(4'b1011, 7,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1011, 1,  4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1011, 19, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1011, 1,  4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            add(4'b1011, 3, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
            add(4'b1011, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
        end
        add(4'b1111, 7,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1111, 1,  4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        add(4'b1111, 8,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Key 1 bounces with 3-edge runs, shorter than the debounce window: nothing accepted.
        for (int k = 0; k < 10; k++)
            add((k % 2 == 0) ? 4'b1101 : 4'b1111, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1111, 8,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Key 0 with a 2-edge release glitch at 10-11: no release; hold timer frozen
        // for the three FSM edges spent outside HELD, so long lands at 30.
        add(4'b1110, 7,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1110, 1,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1110, 2,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1111, 2,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1110, 18, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1110, 1,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add(4'b1111, 7,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1111, 1,  4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(4'b1111, 3,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        rst_n = 1'b0;
        kif.key_in = 4'b1111;
        repeat (3) @(negedge clk);
        chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        run(4'b1111, 3, mid);
        chk("idle.between", mid, 4'b0000);

        foreach (vecs[i]) begin
            string name;
            name = $sformatf("row%0d", i);
            run(vecs[i].key, vecs[i].n, mid);
            chk_all(name, vecs[i].lvl, vecs[i].prs, vecs[i].rls, vecs[i].lng, vecs[i].rpt);
            if (vecs[i].n > 1)
                chk({name, ".between"}, mid, 4'b0000);
        end

        // Key 3 held, key 0 mid-debounce, then async reset with both pins still pressed.
        run(4'b0111, 8, mid);
        chk("rst.pre_level", kif.key_level, 4'b1000);
        chk("rst.pre_between", mid, 4'b0000);
        run(4'b0110, 4, mid);
        chk("rst.pre_db_level", kif.key_level, 4'b1000);
        #2 rst_n = 1'b0;
        #1 chk_all("rst.async", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        chk("rst.held_level", kif.key_level, 4'b0000);
        rst_n = 1'b1;
        run(4'b0110, 7, mid);
        chk("rst.wait_press", kif.press_pulse, 4'b0000);
        chk("rst.wait_between", mid, 4'b0000);
        run(4'b0110, 1, mid);
        chk_all("rst.fresh_press", 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        run(4'b1111, 10, mid);
        chk("rst.final_level", kif.key_level, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
